// File: rtl/mem_rd_desc_walker_pkg.sv
// Shared widths, descriptor packing and state encoding
// for the descriptor-driven read-request walker.
package mem_rd_desc_walker_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int TX_SIZE_W_DEF   = 20;
  localparam int RD_LOOP_W_DEF   = 10;
  localparam int D_TYPE_W_DEF    = 2;
  localparam int DESC_ADDR_W_DEF = 4;

  // Packed MSB->LSB: {type, base, stride, tx_size, loop_max}
  localparam int DESC_W_DEF =
    D_TYPE_W_DEF + ADDR_W_DEF + ADDR_W_DEF +
    TX_SIZE_W_DEF + RD_LOOP_W_DEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ISSUE  = 2'd2,
    S_FINISH = 2'd3
  } walk_state_e;

endpackage

// File: rtl/mem_rd_desc_walker_desc_table.sv
// Descriptor table: simple dual-port RAM, sync write,
// registered read that returns same-cycle write data.
module desc_table_ram
  import mem_rd_desc_walker_pkg::*;
#(
  parameter int W  = DESC_W_DEF,
  parameter int AW = DESC_ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (wr_en && wr_addr == rd_addr) rd_data_q <= wr_data;
    else rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_rd_desc_walker.sv
// Walks the descriptor table and issues strided
// read requests over a valid/ready handshake.
module mem_rd_desc_walker
  import mem_rd_desc_walker_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int BASE_ADDR_W   = ADDR_W,
  parameter int OFFSET_ADDR_W = ADDR_W,
  parameter int TX_SIZE_WIDTH = TX_SIZE_W_DEF,
  parameter int RD_LOOP_W     = RD_LOOP_W_DEF,
  parameter int D_TYPE_W      = D_TYPE_W_DEF,
  parameter int DESC_ADDR_W   = DESC_ADDR_W_DEF,
  parameter int DESC_W        = D_TYPE_W + BASE_ADDR_W +
    OFFSET_ADDR_W + TX_SIZE_WIDTH + RD_LOOP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_wr_en,
  input  logic [DESC_ADDR_W-1:0]   cfg_wr_addr,
  input  logic [DESC_W-1:0]        cfg_wr_data,
  input  logic [DESC_ADDR_W:0]     cfg_num_desc,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_req,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic [D_TYPE_W-1:0]      rd_type,
  output logic [DESC_ADDR_W-1:0]   rd_desc_idx,
  output logic [31:0]              rd_count
);

  localparam int LOOP_LSB = 0;
  localparam int TX_LSB   = LOOP_LSB + RD_LOOP_W;
  localparam int OFF_LSB  = TX_LSB + TX_SIZE_WIDTH;
  localparam int BASE_LSB = OFF_LSB + OFFSET_ADDR_W;
  localparam int TYPE_LSB = BASE_LSB + BASE_ADDR_W;

  walk_state_e state_q, state_d;
  logic [DESC_ADDR_W-1:0]   idx_q, idx_d;
  logic [DESC_ADDR_W:0]     num_q, num_d;
  logic [RD_LOOP_W-1:0]     cnt_q, cnt_d;
  logic [RD_LOOP_W-1:0]     loop_max_q, loop_max_d;
  logic [ADDR_W-1:0]        stride_q, stride_d;
  logic                     rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [TX_SIZE_WIDTH-1:0] rd_size_q, rd_size_d;
  logic [D_TYPE_W-1:0]      rd_type_q, rd_type_d;
  logic [31:0]              rd_count_q, rd_count_d;

  logic [DESC_W-1:0]        desc;
  logic [DESC_ADDR_W:0]     idx_nxt;
  logic                     hs;
  logic                     tbl_we;

  assign tbl_we = cfg_wr_en && (state_q == S_IDLE);

  // Read address follows idx_d so the entry is ready
  // during the LOAD cycle.
  desc_table_ram #(
    .W  (DESC_W),
    .AW (DESC_ADDR_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (tbl_we),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (idx_d),
    .rd_data (desc)
  );

  assign hs      = rd_req_q && rd_ready;
  assign idx_nxt = {1'b0, idx_q} + (DESC_ADDR_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    loop_max_d = loop_max_q;
    stride_d   = stride_q;
    rd_req_d   = rd_req_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_type_d  = rd_type_q;
    rd_count_d = rd_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_count_d = '0;
          num_d      = cfg_num_desc;
          idx_d      = '0;
          state_d    = (cfg_num_desc != '0) ?
                       S_LOAD : S_FINISH;
        end
      end
      S_LOAD: begin
        cnt_d      = '0;
        loop_max_d = desc[LOOP_LSB +: RD_LOOP_W];
        rd_size_d  = desc[TX_LSB +: TX_SIZE_WIDTH];
        stride_d   = ADDR_W'(desc[OFF_LSB +: OFFSET_ADDR_W]);
        rd_addr_d  = ADDR_W'(desc[BASE_LSB +: BASE_ADDR_W]);
        rd_type_d  = desc[TYPE_LSB +: D_TYPE_W];
        rd_req_d   = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (hs) begin
          rd_count_d = rd_count_q + 32'd1;
          unique case (1'b1)
            (cnt_q < loop_max_q): begin
              cnt_d     = cnt_q + RD_LOOP_W'(1);
              rd_addr_d = rd_addr_q + stride_q;
            end
            (cnt_q >= loop_max_q && idx_nxt < num_q): begin
              idx_d    = idx_nxt[DESC_ADDR_W-1:0];
              rd_req_d = 1'b0;
              state_d  = S_LOAD;
            end
            default: begin
              rd_req_d = 1'b0;
              state_d  = S_FINISH;
            end
          endcase
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      loop_max_q <= '0;
      stride_q   <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_type_q  <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      loop_max_q <= loop_max_d;
      stride_q   <= stride_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_type_q  <= rd_type_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign busy        = (state_q == S_LOAD) ||
                       (state_q == S_ISSUE);
  assign done        = (state_q == S_FINISH);
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign rd_req_size = rd_size_q;
  assign rd_type     = rd_type_q;
  assign rd_desc_idx = idx_q;
  assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_mem_rd_desc_walker.sv
// Directed bench for mem_rd_desc_walker: 32-bit and
// 16-bit address instances with hand-computed vectors.
module tb_mem_rd_desc_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [95:0] cfg_wr_data;
  logic [4:0]  cfg_num_desc;
  logic        start;
  logic        busy, done, rd_req, rd_ready;
  logic [31:0] rd_addr;
  logic [19:0] rd_req_size;
  logic [1:0]  rd_type;
  logic [3:0]  rd_desc_idx;
  logic [31:0] rd_count;

  logic        w16_en;
  logic [63:0] w16_data;
  logic [4:0]  n16;
  logic        s16;
  logic        busy16, done16, req16;
  logic        rdy16 = 1'b1;
  logic [15:0] addr16;
  logic [19:0] size16;
  logic [1:0]  type16;
  logic [3:0]  idx16;
  logic [31:0] cnt16;

  always #5 clk = ~clk;

  mem_rd_desc_walker dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_num_desc(cfg_num_desc),
    .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_req_size(rd_req_size),
    .rd_type(rd_type), .rd_desc_idx(rd_desc_idx),
    .rd_count(rd_count)
  );

  mem_rd_desc_walker #(.ADDR_W(16)) dut16 (
    .clk(clk), .reset(reset),
    .cfg_wr_en(w16_en), .cfg_wr_addr(4'd0),
    .cfg_wr_data(w16_data), .cfg_num_desc(n16),
    .start(s16), .busy(busy16), .done(done16),
    .rd_req(req16), .rd_ready(rdy16),
    .rd_addr(addr16), .rd_req_size(size16),
    .rd_type(type16), .rd_desc_idx(idx16),
    .rd_count(cnt16)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] hs_addr[$];
  logic [19:0] hs_size[$];
  logic [1:0]  hs_type[$];
  logic [3:0]  hs_idx[$];
  int          hs_cyc[$];
  int done_cyc, done_cnt, req_seen, stable_err;
  logic        s_busy, s_done, s_req;
  logic [31:0] s_addr, s_cnt;
  logic [19:0] s_size;
  logic [1:0]  s_type;
  logic [3:0]  s_idx;
  logic [15:0] stall_pat = 16'b1001_0110_0101_1001;

  function automatic logic [95:0] mk(
    input logic [1:0] t, input logic [31:0] b,
    input logic [31:0] s, input logic [19:0] z,
    input logic [9:0] l);
    return {t, b, s, z, l};
  endfunction

  task automatic cfg_write(input logic [3:0] a,
                           input logic [95:0] d);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // k counts cycles after the start cycle (start at k=0)
  task automatic run(input int nd, input int maxc,
                     input bit stall, input int pulse_at,
                     input int wr_at, input int rst_at);
    logic [31:0] p_addr;
    logic [19:0] p_size;
    bit          p_stall;
    hs_addr.delete(); hs_size.delete(); hs_type.delete();
    hs_idx.delete();  hs_cyc.delete();
    done_cyc = -1; done_cnt = 0; req_seen = 0;
    stable_err = 0; p_stall = 0; p_addr = '0; p_size = '0;
    @(negedge clk);
    cfg_num_desc = 5'(nd); start = 1'b1; rd_ready = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      cfg_wr_en = (k == wr_at);
      cfg_wr_addr = 4'd0;
      cfg_wr_data = mk(2'd3, 32'h5000, 32'h4, 20'd1, 10'd0);
      if (k == rst_at + 1) begin
        s_busy = busy; s_done = done; s_req = rd_req;
        s_addr = rd_addr; s_cnt = rd_count;
        s_size = rd_req_size; s_type = rd_type;
        s_idx = rd_desc_idx;
        reset = 1'b0;
      end
      if (k == rst_at) reset = 1'b1;
      rd_ready = stall ? stall_pat[k % 16] : 1'b1;
      if (p_stall && (!rd_req || rd_addr !== p_addr ||
          rd_req_size !== p_size))
        stable_err++;
      if (rd_req) req_seen++;
      if (rd_req && rd_ready && !reset) begin
        hs_addr.push_back(rd_addr);
        hs_size.push_back(rd_req_size);
        hs_type.push_back(rd_type);
        hs_idx.push_back(rd_desc_idx);
        hs_cyc.push_back(k);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      p_stall = rd_req && !rd_ready;
      p_addr = rd_addr; p_size = rd_req_size;
    end
    @(negedge clk);
    start = 1'b0; cfg_wr_en = 1'b0; rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, rd_req} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000",
               {busy, done, rd_req});
    end
    tests++;
    if (rd_addr !== 32'h0 || rd_count !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr_cnt: got %h/%h want 0/0",
               rd_addr, rd_count);
    end
    tests++;
    if ({rd_req_size, rd_type, rd_desc_idx} !== 26'h0) begin
      fails++;
      $display("FAIL reset_fields: got %h want 0",
               {rd_req_size, rd_type, rd_desc_idx});
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_a [4];
    exp_a = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
    cfg_write(4'd0, mk(2'd1, 32'h1000, 32'h40, 20'd16, 10'd3));
    run(1, 10, 0, -1, -1, -10);
    tests++;
    if (hs_addr.size() != 4) begin
      fails++;
      $display("FAIL single_count: got %0d want 4",
               hs_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hs_addr[i] !== exp_a[i] || hs_cyc[i] != i + 2 ||
          hs_size[i] !== 20'd16 || hs_type[i] !== 2'd1) begin
        fails++;
        $display("FAIL single_req%0d: got %h@%0d want %h@%0d",
                 i, hs_addr[i], hs_cyc[i], exp_a[i], i + 2);
      end
    end
    tests++;
    if (done_cyc != 6 || done_cnt != 1) begin
      fails++;
      $display("FAIL single_done: got %0d x%0d want 6 x1",
               done_cyc, done_cnt);
    end
    tests++;
    if (rd_count !== 32'd4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_rd_count: got %0d want 4",
               rd_count);
    end
  endtask

  task automatic test_two();
    logic [31:0] exp_a [3];
    int          exp_c [3];
    logic [3:0]  exp_i [3];
    exp_a = '{32'h0, 32'h8, 32'h100};
    exp_c = '{2, 3, 5};
    exp_i = '{4'd0, 4'd0, 4'd1};
    cfg_write(4'd0, mk(2'd0, 32'h0, 32'h8, 20'd4, 10'd1));
    cfg_write(4'd1, mk(2'd2, 32'h100, 32'h4, 20'd0, 10'd0));
    run(2, 10, 0, -1, -1, -10);
    tests++;
    if (hs_addr.size() != 3) begin
      fails++;
      $display("FAIL two_count: got %0d want 3",
               hs_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hs_addr[i] !== exp_a[i] || hs_cyc[i] != exp_c[i] ||
          hs_idx[i] !== exp_i[i]) begin
        fails++;
        $display("FAIL two_req%0d: got %h@%0d i%0d want %h@%0d i%0d",
                 i, hs_addr[i], hs_cyc[i], hs_idx[i],
                 exp_a[i], exp_c[i], exp_i[i]);
      end
    end
    tests++;
    if (hs_size[2] !== 20'd0 || hs_type[2] !== 2'd2) begin
      fails++;
      $display("FAIL two_zero_size: got %0d/%0d want 0/2",
               hs_size[2], hs_type[2]);
    end
    tests++;
    if (done_cyc != 6 || rd_count !== 32'd3) begin
      fails++;
      $display("FAIL two_done: got %0d cnt %0d want 6 cnt 3",
               done_cyc, rd_count);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_a [4];
    exp_a = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
    cfg_write(4'd0, mk(2'd1, 32'h1000, 32'h40, 20'd16, 10'd3));
    run(1, 30, 1, -1, -1, -10);
    tests++;
    if (hs_addr.size() != 4 || stable_err != 0) begin
      fails++;
      $display("FAIL stall_hs: got %0d unstable %0d want 4/0",
               hs_addr.size(), stable_err);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hs_addr[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL stall_req%0d: got %h want %h",
                 i, hs_addr[i], exp_a[i]);
      end
    end
    tests++;
    if (done_cnt != 1 || rd_count !== 32'd4) begin
      fails++;
      $display("FAIL stall_done: got %0d cnt %0d want 1 cnt 4",
               done_cnt, rd_count);
    end
  endtask

  task automatic test_num_zero();
    run(0, 6, 0, -1, -1, -10);
    tests++;
    if (done_cyc != 1 || done_cnt != 1 || req_seen != 0) begin
      fails++;
      $display("FAIL num_zero: got done %0d x%0d req %0d want 1 x1 req 0",
               done_cyc, done_cnt, req_seen);
    end
    tests++;
    if (rd_count !== 32'd0) begin
      fails++;
      $display("FAIL num_zero_cnt: got %0d want 0", rd_count);
    end
  endtask

  task automatic test_busy_start();
    cfg_write(4'd0, mk(2'd1, 32'h1000, 32'h40, 20'd16, 10'd3));
    run(1, 14, 0, 3, -1, -10);
    tests++;
    if (done_cnt != 1 || hs_addr.size() != 4 ||
        rd_count !== 32'd4) begin
      fails++;
      $display("FAIL busy_start: got done x%0d hs %0d cnt %0d want x1 4 4",
               done_cnt, hs_addr.size(), rd_count);
    end
  endtask

  task automatic test_busy_write();
    cfg_write(4'd0, mk(2'd1, 32'h1000, 32'h40, 20'd16, 10'd3));
    run(1, 10, 0, -1, 3, -10);
    run(1, 10, 0, -1, -1, -10);
    tests++;
    if (hs_addr[0] !== 32'h1000 || hs_type[0] !== 2'd1 ||
        hs_addr.size() != 4) begin
      fails++;
      $display("FAIL busy_write: got %h t%0d n%0d want 1000 t1 n4",
               hs_addr[0], hs_type[0], hs_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(4'd0, mk(2'd1, 32'h1000, 32'h40, 20'd16, 10'd3));
    run(1, 12, 0, -1, -1, 3);
    tests++;
    if ({s_busy, s_done, s_req} !== 3'b000 ||
        s_addr !== 32'h0 || s_cnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_out: got %b %h %h want 000 0 0",
               {s_busy, s_done, s_req}, s_addr, s_cnt);
    end
    tests++;
    if ({s_size, s_type, s_idx} !== 26'h0) begin
      fails++;
      $display("FAIL reset_mid_fields: got %h want 0",
               {s_size, s_type, s_idx});
    end
    tests++;
    if (done_cnt != 0) begin
      fails++;
      $display("FAIL reset_mid_done: got %0d want 0", done_cnt);
    end
    run(1, 10, 0, -1, -1, -10);
    tests++;
    if (hs_addr.size() != 4 || hs_addr[0] !== 32'h1000 ||
        hs_addr[3] !== 32'h10C0 || done_cyc != 6) begin
      fails++;
      $display("FAIL reset_replay: got n%0d %h..%h d%0d want n4 1000..10c0 d6",
               hs_addr.size(), hs_addr[0], hs_addr[3], done_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] got [$];
    logic [15:0] exp_a [3];
    int          dn;
    exp_a = '{16'hFFF0, 16'h0000, 16'h0010};
    dn = 0;
    @(negedge clk);
    w16_en = 1'b1;
    w16_data = {2'd1, 16'hFFF0, 16'h0010, 20'd8, 10'd2};
    @(negedge clk);
    w16_en = 1'b0; n16 = 5'd1; s16 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      s16 = 1'b0;
      if (req16) got.push_back(addr16);
      if (done16) dn++;
    end
    tests++;
    if (got.size() != 3 || dn != 1) begin
      fails++;
      $display("FAIL wrap_count: got %0d done x%0d want 3 x1",
               got.size(), dn);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got[i] !== exp_a[i]) begin
        fails++;
        $display("FAIL wrap_req%0d: got %h want %h",
                 i, got[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0;
    cfg_wr_data = '0; cfg_num_desc = '0; start = 1'b0;
    rd_ready = 1'b1; w16_en = 1'b0; w16_data = '0;
    n16 = '0; s16 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_single();
    test_two();
    test_stall();
    test_num_zero();
    test_busy_start();
    test_busy_write();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
